// File: rtl/vx_csr_rmw_issuer_pkg.sv
// ---------------------------------------------------------------------------
// vx_csr_rmw_issuer_pkg
//   Shared types and widths for the CSR read-modify-write issuer slice.
//   NW_BITS / CSR_ADDR_BITS / CSR_WIDTH mirror the core-wide defines so the
//   issuer and its ALU agree on widths without a header include.
//   csr_op_e is the 2-bit CSR operation code carried from issue:
//     00 read-only, 01 RW (write), 10 RS (set bits), 11 RC (clear bits).
// ---------------------------------------------------------------------------
package vx_csr_rmw_issuer_pkg;

  localparam int unsigned NW_BITS       = 2;
  localparam int unsigned CSR_ADDR_BITS = 12;
  localparam int unsigned CSR_WIDTH     = 32;

  typedef enum logic [1:0] {
    CSR_OP_RO = 2'b00,
    CSR_OP_RW = 2'b01,
    CSR_OP_RS = 2'b10,
    CSR_OP_RC = 2'b11
  } csr_op_e;

  // RW always writes (x0 source writes zero); RS/RC with a zero source are
  // pure reads; read-only never writes.
  function automatic logic csr_op_writes(input csr_op_e op, input logic src_zero);
    return (op == CSR_OP_RW) ||
           (((op == CSR_OP_RS) || (op == CSR_OP_RC)) && !src_zero);
  endfunction

endpackage

// File: rtl/vx_csr_rmw_alu.sv
// ---------------------------------------------------------------------------
// vx_csr_rmw_alu
//   Combinational CSR modify step: computes the new CSR value from the old
//   value, the source operand and the operation.
//   Ports:
//     old_value  in   32  CSR value before modification (possibly forwarded)
//     operand    in   32  rs1 value or zimm
//     op         in   2   csr_op_e operation
//     new_value  out  32  value to write back (read-only passes old through)
// ---------------------------------------------------------------------------
module vx_csr_rmw_alu
  import vx_csr_rmw_issuer_pkg::*;
(
  input  logic [31:0] old_value,
  input  logic [31:0] operand,
  input  csr_op_e     op,
  output logic [31:0] new_value
);

  always_comb begin
    new_value = old_value;
    case (op)
      CSR_OP_RW: new_value = operand;
      CSR_OP_RS: new_value = old_value | operand;
      CSR_OP_RC: new_value = old_value & ~operand;
      default:   new_value = old_value;
    endcase
  end

endmodule

// File: rtl/vx_csr_rmw_issuer.sv
// ---------------------------------------------------------------------------
// vx_csr_rmw_issuer
//   Initiator side of the core CSR read/write port. Two single-entry stages:
//     S1  reads the CSR file (combinational read data) and computes the
//         read-modify-write result, forwarding the pending S2 write when it
//         targets the same wid/addr (or stalling on a match if FWD_ENABLE=0).
//     S2  holds the old value for writeback and issues the CSR write exactly
//         once, on the cycle its response handshakes.
//   Ports:
//     clk, reset                      clock, synchronous active-high reset
//     req_valid/req_ready             request handshake from issue
//     req_wid/addr/op/data/src_zero/tag  decoded CSR instruction
//     csr_read_enable/addr/wid        S1 read port to CSR file
//     csr_read_data                   combinational read data from CSR file
//     csr_write_enable/addr/wid/data  S2 write port; write lands on the edge
//     rsp_valid/rsp_ready             response handshake to writeback
//     rsp_wid/rsp_data/rsp_tag        old CSR value and echoed tag
//     busy                            either stage occupied
// ---------------------------------------------------------------------------
module vx_csr_rmw_issuer
  import vx_csr_rmw_issuer_pkg::*;
#(
  parameter int unsigned TAG_WIDTH  = 8,
  parameter bit          FWD_ENABLE = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,

  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [NW_BITS-1:0]       req_wid,
  input  logic [CSR_ADDR_BITS-1:0] req_addr,
  input  logic [1:0]               req_op,
  input  logic [31:0]              req_data,
  input  logic                     req_src_zero,
  input  logic [TAG_WIDTH-1:0]     req_tag,

  output logic                     csr_read_enable,
  output logic [CSR_ADDR_BITS-1:0] csr_read_addr,
  output logic [NW_BITS-1:0]       csr_read_wid,
  input  logic [31:0]              csr_read_data,

  output logic                     csr_write_enable,
  output logic [CSR_ADDR_BITS-1:0] csr_write_addr,
  output logic [NW_BITS-1:0]       csr_write_wid,
  output logic [CSR_WIDTH-1:0]     csr_write_data,

  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [NW_BITS-1:0]       rsp_wid,
  output logic [31:0]              rsp_data,
  output logic [TAG_WIDTH-1:0]     rsp_tag,

  output logic                     busy
);

  // S1 (read) registers
  logic                     s1_valid_q,    s1_valid_d;
  logic [NW_BITS-1:0]       s1_wid_q,      s1_wid_d;
  logic [CSR_ADDR_BITS-1:0] s1_addr_q,     s1_addr_d;
  csr_op_e                  s1_op_q,       s1_op_d;
  logic [31:0]              s1_data_q,     s1_data_d;
  logic                     s1_src_zero_q, s1_src_zero_d;
  logic [TAG_WIDTH-1:0]     s1_tag_q,      s1_tag_d;

  // S2 (write/respond) registers
  logic                     s2_valid_q,    s2_valid_d;
  logic [NW_BITS-1:0]       s2_wid_q,      s2_wid_d;
  logic [CSR_ADDR_BITS-1:0] s2_addr_q,     s2_addr_d;
  logic [TAG_WIDTH-1:0]     s2_tag_q,      s2_tag_d;
  logic [31:0]              s2_old_q,      s2_old_d;
  logic [CSR_WIDTH-1:0]     s2_wdata_q,    s2_wdata_d;
  logic                     s2_wen_q,      s2_wen_d;

  logic        req_fire;
  logic        s2_fire;
  logic        fwd_hit;
  logic        s1_hold;
  logic        s1_adv;
  logic [31:0] s2_wdata_ext;
  logic [31:0] s1_old;
  logic [31:0] s1_new;
  logic        s1_wen;

  assign s2_fire      = s2_valid_q & rsp_ready;
  assign s2_wdata_ext = 32'(s2_wdata_q);

  assign fwd_hit = s2_valid_q & s2_wen_q &
                   (s2_addr_q == s1_addr_q) & (s2_wid_q == s1_wid_q);

  // Without forwarding S1 waits for the matching write to land, then reads
  // the updated value straight from the CSR file.
  assign s1_hold = FWD_ENABLE ? 1'b0 : fwd_hit;
  assign s1_old  = (FWD_ENABLE && fwd_hit) ? s2_wdata_ext : csr_read_data;

  assign s1_adv    = s1_valid_q & (~s2_valid_q | s2_fire) & ~s1_hold;
  assign req_ready = ~s1_valid_q | s1_adv;
  assign req_fire  = req_valid & req_ready;

  assign s1_wen = csr_op_writes(s1_op_q, s1_src_zero_q);

  vx_csr_rmw_alu u_alu (
    .old_value (s1_old),
    .operand   (s1_data_q),
    .op        (s1_op_q),
    .new_value (s1_new)
  );

  always_comb begin
    s1_valid_d    = s1_valid_q;
    s1_wid_d      = s1_wid_q;
    s1_addr_d     = s1_addr_q;
    s1_op_d       = s1_op_q;
    s1_data_d     = s1_data_q;
    s1_src_zero_d = s1_src_zero_q;
    s1_tag_d      = s1_tag_q;

    if (s1_adv) s1_valid_d = 1'b0;
    if (req_fire) begin
      s1_valid_d    = 1'b1;
      s1_wid_d      = req_wid;
      s1_addr_d     = req_addr;
      s1_op_d       = csr_op_e'(req_op);
      s1_data_d     = req_data;
      s1_src_zero_d = req_src_zero;
      s1_tag_d      = req_tag;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_wid_d   = s2_wid_q;
    s2_addr_d  = s2_addr_q;
    s2_tag_d   = s2_tag_q;
    s2_old_d   = s2_old_q;
    s2_wdata_d = s2_wdata_q;
    s2_wen_d   = s2_wen_q;

    if (s2_fire) s2_valid_d = 1'b0;
    if (s1_adv) begin
      s2_valid_d = 1'b1;
      s2_wid_d   = s1_wid_q;
      s2_addr_d  = s1_addr_q;
      s2_tag_d   = s1_tag_q;
      s2_old_d   = s1_old;
      s2_wdata_d = s1_new[CSR_WIDTH-1:0];
      s2_wen_d   = s1_wen;
    end
  end

  // Only the valid bits are reset; payload registers are qualified by them.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
    s1_wid_q      <= s1_wid_d;
    s1_addr_q     <= s1_addr_d;
    s1_op_q       <= s1_op_d;
    s1_data_q     <= s1_data_d;
    s1_src_zero_q <= s1_src_zero_d;
    s1_tag_q      <= s1_tag_d;
    s2_wid_q      <= s2_wid_d;
    s2_addr_q     <= s2_addr_d;
    s2_tag_q      <= s2_tag_d;
    s2_old_q      <= s2_old_d;
    s2_wdata_q    <= s2_wdata_d;
    s2_wen_q      <= s2_wen_d;
  end

  assign csr_read_enable = s1_valid_q;
  assign csr_read_addr   = s1_addr_q;
  assign csr_read_wid    = s1_wid_q;

  // Gated by reset so an entry caught in S2 when reset hits is dropped
  // without touching the CSR file.
  assign csr_write_enable = s2_fire & s2_wen_q & ~reset;
  assign csr_write_addr   = s2_addr_q;
  assign csr_write_wid    = s2_wid_q;
  assign csr_write_data   = s2_wdata_q;

  assign rsp_valid = s2_valid_q;
  assign rsp_wid   = s2_wid_q;
  assign rsp_data  = s2_old_q;
  assign rsp_tag   = s2_tag_q;

  assign busy = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_vx_csr_rmw_issuer.sv
// ---------------------------------------------------------------------------
// tb_vx_csr_rmw_issuer
//   Bench for vx_csr_rmw_issuer with a behavioural CSR file (combinational
//   read, write on the clock edge) and an in-order architectural model that
//   applies each CSR instruction at acceptance time.
// ---------------------------------------------------------------------------
module tb_vx_csr_rmw_issuer;
  import vx_csr_rmw_issuer_pkg::*;

  localparam int unsigned TW = 8;

  typedef struct packed {
    logic [NW_BITS-1:0] wid;
    logic [31:0]        data;
    logic [TW-1:0]      tag;
  } rsp_t;

  typedef struct packed {
    logic [NW_BITS-1:0]       wid;
    logic [CSR_ADDR_BITS-1:0] addr;
    logic [31:0]              data;
  } wr_t;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     req_valid;
  logic                     req_ready;
  logic [NW_BITS-1:0]       req_wid;
  logic [CSR_ADDR_BITS-1:0] req_addr;
  logic [1:0]               req_op;
  logic [31:0]              req_data;
  logic                     req_src_zero;
  logic [TW-1:0]            req_tag;
  logic                     csr_read_enable;
  logic [CSR_ADDR_BITS-1:0] csr_read_addr;
  logic [NW_BITS-1:0]       csr_read_wid;
  logic [31:0]              csr_read_data;
  logic                     csr_write_enable;
  logic [CSR_ADDR_BITS-1:0] csr_write_addr;
  logic [NW_BITS-1:0]       csr_write_wid;
  logic [CSR_WIDTH-1:0]     csr_write_data;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [NW_BITS-1:0]       rsp_wid;
  logic [31:0]              rsp_data;
  logic [TW-1:0]            rsp_tag;
  logic                     busy;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  vx_csr_rmw_issuer #(.TAG_WIDTH(TW), .FWD_ENABLE(1'b1)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_wid          (req_wid),
    .req_addr         (req_addr),
    .req_op           (req_op),
    .req_data         (req_data),
    .req_src_zero     (req_src_zero),
    .req_tag          (req_tag),
    .csr_read_enable  (csr_read_enable),
    .csr_read_addr    (csr_read_addr),
    .csr_read_wid     (csr_read_wid),
    .csr_read_data    (csr_read_data),
    .csr_write_enable (csr_write_enable),
    .csr_write_addr   (csr_write_addr),
    .csr_write_wid    (csr_write_wid),
    .csr_write_data   (csr_write_data),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_wid          (rsp_wid),
    .rsp_data         (rsp_data),
    .rsp_tag          (rsp_tag),
    .busy             (busy)
  );

  // ---- behavioural CSR file ----
  logic [31:0]              csr_mem [0:3][0:4095];
  logic                     pre_en;
  logic [NW_BITS-1:0]       pre_wid;
  logic [CSR_ADDR_BITS-1:0] pre_addr;
  logic [31:0]              pre_val;

  assign csr_read_data = csr_mem[csr_read_wid][csr_read_addr];

  always @(posedge clk) begin
    if (pre_en) csr_mem[pre_wid][pre_addr] <= pre_val;
    else if (csr_write_enable) csr_mem[csr_write_wid][csr_write_addr] <= 32'(csr_write_data);
  end

  // ---- observation (recorded only; compared in the test tasks) ----
  rsp_t obs_rsp[$];
  wr_t  obs_wr[$];

  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) obs_rsp.push_back('{rsp_wid, rsp_data, rsp_tag});
    if (csr_write_enable) obs_wr.push_back('{csr_write_wid, csr_write_addr, 32'(csr_write_data)});
  end

  // ---- architectural reference model ----
  logic [31:0]   ref_mem [0:3][0:4095];
  rsp_t          exp_rsp[$];
  wr_t           exp_wr[$];
  logic [TW-1:0] tag_ctr = '0;

  task automatic preload(input logic [NW_BITS-1:0] w, input logic [CSR_ADDR_BITS-1:0] a,
                         input logic [31:0] v);
    pre_en = 1'b1; pre_wid = w; pre_addr = a; pre_val = v;
    @(posedge clk); #1;
    pre_en = 1'b0;
    ref_mem[w][a] = v;
  endtask

  // Presents one request, waits (bounded) for acceptance and applies the
  // instruction to the reference model in program order.
  task automatic send_req(input logic [NW_BITS-1:0] w, input logic [CSR_ADDR_BITS-1:0] a,
                          input logic [1:0] op, input logic [31:0] d, input logic sz);
    logic rdy;
    int unsigned n;
    logic [31:0] old_v, new_v;
    logic wen;
    req_valid = 1'b1; req_wid = w; req_addr = a; req_op = op;
    req_data = d; req_src_zero = sz; req_tag = tag_ctr;
    n = 0;
    rdy = 1'b0;
    forever begin
      @(negedge clk); rdy = req_ready;
      @(posedge clk);
      if (rdy) break;
      n++;
      if (n > 200) begin
        total++; bad++;
        $display("FAIL accept_timeout req_ready=%0b required=1", rdy);
        break;
      end
    end
    #1;
    req_valid = 1'b0;
    if (rdy) begin
      old_v = ref_mem[w][a];
      case (op)
        2'b01:   new_v = d;
        2'b10:   new_v = old_v | d;
        2'b11:   new_v = old_v & ~d;
        default: new_v = old_v;
      endcase
      wen = (op == 2'b01) || ((op == 2'b10 || op == 2'b11) && !sz);
      exp_rsp.push_back('{w, old_v, tag_ctr});
      if (wen) begin
        ref_mem[w][a] = new_v;
        exp_wr.push_back('{w, a, new_v});
      end
      tag_ctr++;
    end
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    @(negedge clk);
    while (busy) begin
      n++;
      if (n > 500) begin
        total++; bad++;
        $display("FAIL drain_timeout busy=%0b required=0", busy);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
  endtask

  // ---- tests ----
  task automatic test_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%0b exp=0", rsp_valid); end
    total++; if (csr_write_enable !== 1'b0) begin bad++; $display("FAIL reset_wen got=%0b exp=0", csr_write_enable); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%0b exp=1", req_ready); end
    total++; if (csr_read_enable !== 1'b0) begin bad++; $display("FAIL reset_ren got=%0b exp=0", csr_read_enable); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_rs();
    int w0;
    logic [TW-1:0] t;
    preload(2'd1, 12'h340, 32'h0000_00F0);
    w0 = obs_wr.size();
    t = tag_ctr;
    send_req(2'd1, 12'h340, 2'b10, 32'h0000_000F, 1'b0);
    @(negedge clk);
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_early_rsp got=%0b exp=0", rsp_valid); end
    @(negedge clk);
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL single_rsp_valid got=%0b exp=1", rsp_valid); end
    total++; if (rsp_data !== 32'h0000_00F0) begin bad++; $display("FAIL single_rsp_data got=%h exp=000000f0", rsp_data); end
    total++; if (rsp_tag !== t || rsp_wid !== 2'd1) begin bad++; $display("FAIL single_rsp_tag got=%h/%0d exp=%h/1", rsp_tag, rsp_wid, t); end
    @(posedge clk); #1;
    drain();
    total++;
    if (obs_wr.size() - w0 != 1) begin bad++; $display("FAIL single_write_count got=%0d exp=1", obs_wr.size() - w0); end
    else if (obs_wr[w0].data !== 32'h0000_00FF || obs_wr[w0].addr !== 12'h340) begin
      bad++; $display("FAIL single_write_data got=%h@%h exp=000000ff@340", obs_wr[w0].data, obs_wr[w0].addr);
    end
    total++; if (csr_mem[1][12'h340] !== 32'h0000_00FF) begin bad++; $display("FAIL single_final got=%h exp=000000ff", csr_mem[1][12'h340]); end
  endtask

  task automatic test_back_to_back();
    int r0;
    int w0;
    preload(2'd2, 12'h300, 32'h0000_00FF);
    r0 = obs_rsp.size(); w0 = obs_wr.size();
    send_req(2'd2, 12'h300, 2'b11, 32'h0000_00F0, 1'b0);
    send_req(2'd2, 12'h300, 2'b10, 32'h0000_0100, 1'b0);
    drain();
    total++;
    if (obs_rsp.size() - r0 != 2) begin bad++; $display("FAIL b2b_rsp_count got=%0d exp=2", obs_rsp.size() - r0); end
    else begin
      total++; if (obs_rsp[r0].data !== 32'h0000_00FF) begin bad++; $display("FAIL b2b_rsp0 got=%h exp=000000ff", obs_rsp[r0].data); end
      total++; if (obs_rsp[r0+1].data !== 32'h0000_000F) begin bad++; $display("FAIL b2b_rsp1_fwd got=%h exp=0000000f", obs_rsp[r0+1].data); end
    end
    total++;
    if (obs_wr.size() - w0 != 2) begin bad++; $display("FAIL b2b_write_count got=%0d exp=2", obs_wr.size() - w0); end
    else if (obs_wr[w0].data !== 32'h0000_000F || obs_wr[w0+1].data !== 32'h0000_010F) begin
      bad++; $display("FAIL b2b_write_data got=%h,%h exp=0000000f,0000010f", obs_wr[w0].data, obs_wr[w0+1].data);
    end
    total++; if (csr_mem[2][12'h300] !== 32'h0000_010F) begin bad++; $display("FAIL b2b_final got=%h exp=0000010f", csr_mem[2][12'h300]); end
  endtask

  task automatic test_no_write();
    int r0;
    int w0;
    preload(2'd0, 12'h341, 32'h1234_5678);
    r0 = obs_rsp.size(); w0 = obs_wr.size();
    send_req(2'd0, 12'h341, 2'b10, 32'h0, 1'b1);
    send_req(2'd0, 12'h341, 2'b00, $urandom, 1'b0);
    send_req(2'd0, 12'h341, 2'b11, 32'h0, 1'b1);
    drain();
    total++;
    if (obs_rsp.size() - r0 != 3) begin bad++; $display("FAIL nowr_rsp_count got=%0d exp=3", obs_rsp.size() - r0); end
    else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (obs_rsp[r0+i].data !== 32'h1234_5678) begin bad++; $display("FAIL nowr_rsp%0d got=%h exp=12345678", i, obs_rsp[r0+i].data); end
      end
    end
    total++; if (obs_wr.size() != w0) begin bad++; $display("FAIL nowr_write_count got=%0d exp=0", obs_wr.size() - w0); end
    total++; if (csr_mem[0][12'h341] !== 32'h1234_5678) begin bad++; $display("FAIL nowr_final got=%h exp=12345678", csr_mem[0][12'h341]); end
  endtask

  task automatic test_backpressure();
    int w0;
    logic [TW-1:0] ta;
    preload(2'd3, 12'h300, 32'hAAAA_0000);
    preload(2'd3, 12'h301, 32'h0000_0005);
    w0 = obs_wr.size();
    rsp_ready = 1'b0;
    ta = tag_ctr;
    send_req(2'd3, 12'h300, 2'b01, 32'hDEAD_BEEF, 1'b0);
    send_req(2'd3, 12'h301, 2'b10, 32'h0000_0030, 1'b0);
    // a third request that must be refused while both stages are full
    req_valid = 1'b1; req_wid = 2'd3; req_addr = 12'h302; req_op = 2'b01;
    req_data = 32'h1; req_src_zero = 1'b0; req_tag = 8'hEE;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_rsp_valid c%0d got=%0b exp=1", c, rsp_valid); end
      total++; if (rsp_data !== 32'hAAAA_0000 || rsp_tag !== ta) begin bad++; $display("FAIL bp_rsp_stable c%0d got=%h/%h exp=aaaa0000/%h", c, rsp_data, rsp_tag, ta); end
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_req_ready c%0d got=%0b exp=0", c, req_ready); end
      total++; if (csr_write_enable !== 1'b0) begin bad++; $display("FAIL bp_wen c%0d got=%0b exp=0", c, csr_write_enable); end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    total++;
    if (obs_wr.size() - w0 != 1) begin bad++; $display("FAIL bp_release_writes got=%0d exp=1", obs_wr.size() - w0); end
    else if (obs_wr[w0].data !== 32'hDEAD_BEEF || obs_wr[w0].addr !== 12'h300) begin
      bad++; $display("FAIL bp_release_data got=%h@%h exp=deadbeef@300", obs_wr[w0].data, obs_wr[w0].addr);
    end
    @(posedge clk); #1;
    drain();
    total++; if (obs_wr.size() - w0 != 2) begin bad++; $display("FAIL bp_total_writes got=%0d exp=2", obs_wr.size() - w0); end
    total++; if (csr_mem[3][12'h301] !== 32'h0000_0035) begin bad++; $display("FAIL bp_final got=%h exp=00000035", csr_mem[3][12'h301]); end
    total++; if (csr_mem[3][12'h302] === 32'h1) begin bad++; $display("FAIL bp_refused_req got=%h exp=!00000001", csr_mem[3][12'h302]); end
  endtask

  task automatic test_reset_midflight();
    int r1;
    int w0;
    preload(2'd1, 12'h305, 32'h0000_0011);
    preload(2'd1, 12'h306, 32'h0000_0022);
    w0 = obs_wr.size();
    rsp_ready = 1'b0;
    send_req(2'd1, 12'h305, 2'b01, 32'h0000_0099, 1'b0);
    send_req(2'd1, 12'h306, 2'b01, 32'h0000_0077, 1'b0);
    reset = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    total++; if (csr_write_enable !== 1'b0) begin bad++; $display("FAIL rst_mid_wen got=%0b exp=0", csr_write_enable); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk); #1;
    total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_mid_state got=%0b/%0b exp=0/0", rsp_valid, busy); end
    total++; if (obs_wr.size() != w0) begin bad++; $display("FAIL rst_mid_writes got=%0d exp=0", obs_wr.size() - w0); end
    total++;
    if (csr_mem[1][12'h305] !== 32'h11 || csr_mem[1][12'h306] !== 32'h22) begin
      bad++; $display("FAIL rst_mid_mem got=%h,%h exp=00000011,00000022", csr_mem[1][12'h305], csr_mem[1][12'h306]);
    end
    @(posedge clk); #1;
    // dropped instructions never retire architecturally
    ref_mem[1][12'h305] = 32'h11;
    ref_mem[1][12'h306] = 32'h22;
    exp_rsp.delete();
    exp_wr.delete();
    r1 = obs_rsp.size();
    send_req(2'd1, 12'h305, 2'b10, 32'h0000_0100, 1'b0);
    drain();
    total++;
    if (obs_rsp.size() - r1 != 1) begin bad++; $display("FAIL rst_after_rsp_count got=%0d exp=1", obs_rsp.size() - r1); end
    else if (obs_rsp[r1].data !== 32'h11) begin bad++; $display("FAIL rst_after_rsp got=%h exp=00000011", obs_rsp[r1].data); end
    total++; if (csr_mem[1][12'h305] !== 32'h111) begin bad++; $display("FAIL rst_after_final got=%h exp=00000111", csr_mem[1][12'h305]); end
  endtask

  bit stop_rdy;

  task automatic test_random();
    int r0;
    int w0;
    logic [CSR_ADDR_BITS-1:0] addrs [3];
    logic [1:0] op;
    logic sz;
    logic [31:0] d;
    addrs[0] = 12'h300; addrs[1] = 12'h340; addrs[2] = 12'h7C0;
    for (int w = 0; w < 2; w++)
      for (int k = 0; k < 3; k++)
        preload(NW_BITS'(w), addrs[k], $urandom);
    exp_rsp.delete();
    exp_wr.delete();
    r0 = obs_rsp.size(); w0 = obs_wr.size();
    stop_rdy = 1'b0;
    fork
      begin
        forever begin
          @(posedge clk); #1;
          if (stop_rdy) break;
          rsp_ready = ($urandom_range(3) != 0);
        end
      end
    join_none
    for (int i = 0; i < 300; i++) begin
      op = 2'($urandom_range(3));
      sz = ($urandom_range(3) == 0);
      d  = sz ? 32'h0 : $urandom;
      if ($urandom_range(3) == 0) begin @(posedge clk); #1; end
      send_req(NW_BITS'($urandom_range(1)), addrs[$urandom_range(2)], op, d, sz);
    end
    stop_rdy = 1'b1;
    @(posedge clk); #2;
    rsp_ready = 1'b1;
    drain();
    total++;
    if (obs_rsp.size() - r0 != exp_rsp.size()) begin
      bad++; $display("FAIL rand_rsp_count got=%0d exp=%0d", obs_rsp.size() - r0, exp_rsp.size());
    end else begin
      for (int i = 0; i < exp_rsp.size(); i++) begin
        total++;
        if (obs_rsp[r0+i] !== exp_rsp[i]) begin
          bad++; $display("FAIL rand_rsp%0d got=w%0d %h t%h exp=w%0d %h t%h", i,
            obs_rsp[r0+i].wid, obs_rsp[r0+i].data, obs_rsp[r0+i].tag, exp_rsp[i].wid, exp_rsp[i].data, exp_rsp[i].tag);
        end
      end
    end
    total++;
    if (obs_wr.size() - w0 != exp_wr.size()) begin
      bad++; $display("FAIL rand_wr_count got=%0d exp=%0d", obs_wr.size() - w0, exp_wr.size());
    end else begin
      for (int i = 0; i < exp_wr.size(); i++) begin
        total++;
        if (obs_wr[w0+i] !== exp_wr[i]) begin
          bad++; $display("FAIL rand_wr%0d got=w%0d %h=%h exp=w%0d %h=%h", i,
            obs_wr[w0+i].wid, obs_wr[w0+i].addr, obs_wr[w0+i].data, exp_wr[i].wid, exp_wr[i].addr, exp_wr[i].data);
        end
      end
    end
    for (int w = 0; w < 2; w++)
      for (int k = 0; k < 3; k++) begin
        total++;
        if (csr_mem[w][addrs[k]] !== ref_mem[w][addrs[k]]) begin
          bad++; $display("FAIL rand_final w%0d %h got=%h exp=%h", w, addrs[k], csr_mem[w][addrs[k]], ref_mem[w][addrs[k]]);
        end
      end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_wid = '0; req_addr = '0; req_op = '0;
    req_data = '0; req_src_zero = 1'b0; req_tag = '0; rsp_ready = 1'b1;
    pre_en = 1'b0; pre_wid = '0; pre_addr = '0; pre_val = '0; stop_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_single_rs();
    test_back_to_back();
    test_no_write();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
